// File: rtl/multi_channel_frame_sender.sv
// multi_channel_frame_sender
//   Collects variable-length payloads from NUM_CHANNELS independent input
//   ports. Each port has its own FIFO. Non-empty FIFOs are served round-robin,
//   and each entry is sent out of one UART as the frame
//   {L, channel, payload bytes LSB first [, checksum]}, where L = ceil(bits/8).
//
// Optional feature: define FRAME_CHECKSUM_EN to append an XOR checksum byte
//   after the payload. The checksum covers L, the channel byte and the payload.
//
// Ports
//   clk, reset    clock; synchronous active-high reset
//   in_valid[c]   push request for channel c
//   in_ready[c]   channel c FIFO not full (combinational from the FIFO count)
//   in_data       flattened payloads; channel c at [c*MAX_BITS_TO_SEND +: MAX_BITS_TO_SEND]
//   in_num_bits   flattened bit counts; channel c at [c*NBW +: NBW]
//   overflow[c]   one-cycle pulse after a push on channel c is dropped
//   frame_active  high from a frame's first UART start until its last byte ends
//   uart_output   serial line, idle high
//
// Handshake: a push is accepted on a clk edge where in_valid[c] && in_ready[c].
//   A push while !in_ready[c] is dropped, and overflow[c] pulses on the next
//   cycle. Toward the UART, start_transmission is pulsed only while busy is
//   low. The cycle after the pulse is skipped because busy rises one cycle late.

module uart_tx #(
   parameter int CLKS_PER_BIT = 10416
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_transmission,
   input  logic [7:0] data,
   output logic       busy,
   output logic       uart_output
);
   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

   tx_state_t     state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (clk_cnt == CW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= TX_IDLE;
         clk_cnt     <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         busy        <= 1'b0;
         uart_output <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: if (start_transmission) begin
               shreg       <= data;
               busy        <= 1'b1;
               uart_output <= 1'b0;
               clk_cnt     <= '0;
               state       <= TX_START;
            end
            TX_START: if (bit_end) begin
               clk_cnt     <= '0;
               bit_idx     <= '0;
               uart_output <= shreg[0];
               state       <= TX_DATA;
            end else clk_cnt <= clk_cnt + 1'b1;
            TX_DATA: if (bit_end) begin
               clk_cnt <= '0;
               if (bit_idx == 3'd7) begin
                  uart_output <= 1'b1;
                  state       <= TX_STOP;
               end else begin
                  bit_idx     <= bit_idx + 1'b1;
                  uart_output <= shreg[1];
                  shreg       <= {1'b0, shreg[7:1]};
               end
            end else clk_cnt <= clk_cnt + 1'b1;
            TX_STOP: if (bit_end) begin
               clk_cnt <= '0;
               busy    <= 1'b0;
               state   <= TX_IDLE;
            end else clk_cnt <= clk_cnt + 1'b1;
            default: state <= TX_IDLE;
         endcase
      end
   end
endmodule

module multi_channel_frame_sender #(
   parameter int CLKS_PER_BIT     = 10416,
   parameter int NUM_CHANNELS     = 4,
   parameter int MAX_BITS_TO_SEND = 128,
   parameter int FIFO_DEPTH       = 8,
   parameter int NBW  = $clog2(MAX_BITS_TO_SEND + 1),
   parameter int MAXB = (MAX_BITS_TO_SEND + 7) / 8
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_CHANNELS-1:0]                in_valid,
   output logic [NUM_CHANNELS-1:0]                in_ready,
   input  logic [NUM_CHANNELS*MAX_BITS_TO_SEND-1:0] in_data,
   input  logic [NUM_CHANNELS*NBW-1:0]            in_num_bits,
   output logic [NUM_CHANNELS-1:0]                overflow,
   output logic                                   frame_active,
   output logic                                   uart_output
);
   localparam int CIW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam int MB  = MAX_BITS_TO_SEND;

   typedef enum logic [2:0] {
      IDLE, LOAD, SEND_LEN, SEND_CH, SEND_DATA,
`ifdef FRAME_CHECKSUM_EN
      SEND_CSUM,
`endif
      TX_WAIT, DONE
   } state_t;

   // Per-channel FIFO storage.
   logic [MB-1:0]  mem_data [NUM_CHANNELS][FIFO_DEPTH];
   logic [NBW-1:0] mem_bits [NUM_CHANNELS][FIFO_DEPTH];
   logic [PW-1:0]  wr_ptr   [NUM_CHANNELS];
   logic [PW-1:0]  rd_ptr   [NUM_CHANNELS];
   logic [PW:0]    count    [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] push_ok, pop_vec;
   logic [NBW-1:0] bits_clamped [NUM_CHANNELS];

   state_t           state, after_wait;
   logic [CIW-1:0]   rr, sel, pick;
   logic             found;
   logic [MB-1:0]    rd_data;
   logic [NBW-1:0]   rd_bits;
   logic [MAXB*8-1:0] lat_data;
   logic [7:0]       len, byte_idx, tx_byte, csum;
   logic [NBW+3:0]   len_sum;
   logic             start_q, busy;

   always_comb begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         in_ready[c] = (count[c] != (PW+1)'(FIFO_DEPTH));
         push_ok[c]  = in_valid[c] && in_ready[c];
         pop_vec[c]  = (state == LOAD) && (sel == CIW'(c));
         bits_clamped[c] = (in_num_bits[c*NBW +: NBW] > NBW'(MB)) ?
                           NBW'(MB) : in_num_bits[c*NBW +: NBW];
      end
   end

   // First non-empty channel at or after rr, wrapping.
   always_comb begin
      int idx;
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         idx = int'(rr) + i;
         if (idx >= NUM_CHANNELS) idx = idx - NUM_CHANNELS;
         if (!found && (count[idx] != '0)) begin
            found = 1'b1;
            pick  = CIW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (push_ok[c]) begin
            mem_data[c][wr_ptr[c]] <= in_data[c*MB +: MB];
            mem_bits[c][wr_ptr[c]] <= bits_clamped[c];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         if (reset) begin
            wr_ptr[c]   <= '0;
            rd_ptr[c]   <= '0;
            count[c]    <= '0;
            overflow[c] <= 1'b0;
         end else begin
            overflow[c] <= in_valid[c] && !in_ready[c];
            if (push_ok[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
            if (pop_vec[c]) rd_ptr[c] <= rd_ptr[c] + 1'b1;
            if (push_ok[c] && !pop_vec[c])      count[c] <= count[c] + 1'b1;
            else if (!push_ok[c] && pop_vec[c]) count[c] <= count[c] - 1'b1;
         end
      end
   end

   assign len_sum = (NBW+4)'(rd_bits) + (NBW+4)'(7);

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         after_wait   <= IDLE;
         rr           <= '0;
         sel          <= '0;
         rd_data      <= '0;
         rd_bits      <= '0;
         lat_data     <= '0;
         len          <= '0;
         byte_idx     <= '0;
         tx_byte      <= '0;
         csum         <= '0;
         start_q      <= 1'b0;
         frame_active <= 1'b0;
      end else begin
         case (state)
            IDLE: if (found) begin
               sel     <= pick;
               rd_data <= mem_data[pick][rd_ptr[pick]];
               rd_bits <= mem_bits[pick][rd_ptr[pick]];
               state   <= LOAD;
            end
            LOAD: begin
               rr       <= (sel == CIW'(NUM_CHANNELS - 1)) ? '0 : sel + 1'b1;
               lat_data <= (MAXB*8)'(rd_data);
               len      <= 8'(len_sum >> 3);
               state    <= (rd_bits == '0) ? IDLE : SEND_LEN;
            end
            SEND_LEN: if (!busy) begin
               start_q      <= 1'b1;
               tx_byte      <= len;
               csum         <= len;
               frame_active <= 1'b1;
               after_wait   <= SEND_CH;
               state        <= TX_WAIT;
            end
            SEND_CH: if (!busy) begin
               start_q    <= 1'b1;
               tx_byte    <= 8'(sel);
               csum       <= csum ^ 8'(sel);
               byte_idx   <= '0;
               after_wait <= SEND_DATA;
               state      <= TX_WAIT;
            end
            SEND_DATA: if (!busy) begin
               start_q <= 1'b1;
               tx_byte <= lat_data[{byte_idx, 3'b000} +: 8];
               csum    <= csum ^ lat_data[{byte_idx, 3'b000} +: 8];
               if (byte_idx == len - 1'b1) begin
`ifdef FRAME_CHECKSUM_EN
                  after_wait <= SEND_CSUM;
`else
                  after_wait <= DONE;
`endif
               end else begin
                  byte_idx   <= byte_idx + 1'b1;
                  after_wait <= SEND_DATA;
               end
               state <= TX_WAIT;
            end
`ifdef FRAME_CHECKSUM_EN
            SEND_CSUM: if (!busy) begin
               start_q    <= 1'b1;
               tx_byte    <= csum;
               after_wait <= DONE;
               state      <= TX_WAIT;
            end
`endif
            // busy is still low here; it rises on the following cycle.
            TX_WAIT: begin
               start_q <= 1'b0;
               state   <= after_wait;
            end
            DONE: if (!busy) begin
               frame_active <= 1'b0;
               state        <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart_tx (
      .clk                (clk),
      .reset              (reset),
      .start_transmission (start_q),
      .data               (tx_byte),
      .busy               (busy),
      .uart_output        (uart_output)
   );
endmodule

// File: tb/tb_multi_channel_frame_sender.sv
// Bench for multi_channel_frame_sender: CLKS_PER_BIT=4, 4 channels,
// 128-bit payloads, FIFO depth 4. A UART receiver at negedge pops expected
// bytes from exp_q.
module tb_multi_channel_frame_sender;
   localparam int CPB = 4, NCH = 4, MB = 128, DEPTH = 4, NBW = 8;

   logic clk = 1'b0;
   logic reset;
   logic [NCH-1:0]     in_valid, in_ready, overflow;
   logic [NCH*MB-1:0]  in_data;
   logic [NCH*NBW-1:0] in_num_bits;
   logic frame_active, uart_output;

   logic [7:0] exp_q[$];
   int n_checks = 0;
   int n_fail = 0;
   int rx_bytes = 0;

   // clock / reset
   always #5 clk = ~clk;

   multi_channel_frame_sender #(
      .CLKS_PER_BIT(CPB), .NUM_CHANNELS(NCH),
      .MAX_BITS_TO_SEND(MB), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_num_bits(in_num_bits), .overflow(overflow),
      .frame_active(frame_active), .uart_output(uart_output)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // expected bytes of one frame
   task automatic exp_frame(input int ch, input logic [127:0] data, input int bits);
      int b, l;
      logic [7:0] byt;
`ifdef FRAME_CHECKSUM_EN
      logic [7:0] cs;
`endif
      b = (bits > MB) ? MB : bits;
      l = (b + 7) / 8;
      if (l != 0) begin
         exp_q.push_back(8'(l));
         exp_q.push_back(8'(ch));
`ifdef FRAME_CHECKSUM_EN
         cs = 8'(l) ^ 8'(ch);
`endif
         for (int i = 0; i < l; i++) begin
            byt = data[i*8 +: 8];
            exp_q.push_back(byt);
`ifdef FRAME_CHECKSUM_EN
            cs = cs ^ byt;
`endif
         end
`ifdef FRAME_CHECKSUM_EN
         exp_q.push_back(cs);
`endif
      end
   endtask

   // monitor: UART receiver and scoreboard
   logic       rx_busy = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_sh = '0;
   logic [7:0] got;
   logic       line_low_seen = 1'b0;

   always @(negedge clk) begin
      if (uart_output !== 1'b1) line_low_seen = 1'b1;
      if (reset) begin
         rx_busy = 1'b0;
         rx_cnt  = 0;
      end else if (!rx_busy) begin
         if (uart_output === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
            check("frame_active at start bit", 32'(frame_active), 1);
         end
      end else begin
         rx_cnt++;
         if ((rx_cnt % CPB == 2) && (rx_cnt / CPB >= 1) && (rx_cnt / CPB <= 8))
            rx_sh = {uart_output, rx_sh[7:1]};
         if (rx_cnt == 9 * CPB + 2) begin
            check("stop bit", 32'(uart_output), 1);
            check("frame_active in stop bit", 32'(frame_active), 1);
            rx_bytes++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected byte: got 0x%0h, expected none", rx_sh);
            end else begin
               got = exp_q.pop_front();
               check("uart byte", 32'(rx_sh), 32'(got));
            end
            rx_busy = 1'b0;
         end
      end
   end

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      in_valid = '0;
      repeat (3) @(negedge clk);
      exp_q.delete();
      check("reset uart_output", 32'(uart_output), 1);
      check("reset frame_active", 32'(frame_active), 0);
      check("reset in_ready", 32'(in_ready), 32'hF);
      check("reset overflow", 32'(overflow), 0);
      reset = 1'b0;
   endtask

   task automatic push(input int ch, input logic [127:0] data, input int bits);
      @(negedge clk);
      in_valid              = '0;
      in_valid[ch]          = 1'b1;
      in_data[ch*MB +: MB]  = data;
      in_num_bits[ch*NBW +: NBW] = 8'(bits);
      @(negedge clk);
      in_valid = '0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !frame_active && !rx_busy) break;
      end
      check(name, (exp_q.size() == 0 && !frame_active) ? 32'd1 : 32'd0, 1);
   endtask

   logic [127:0] long_data, seq_data, d;
   int rx_before;
   logic found_it;

   initial begin
      reset = 1'b1; in_valid = '0; in_data = '0; in_num_bits = '0;
      long_data = 128'hFFEEDDCCBBAA99887766554433221100;
      seq_data  = 128'h0F0E0D0C0B0A09080706050403020100;

      // 1: single 12-bit frame
      do_reset();
      exp_q.push_back(8'h02); exp_q.push_back(8'h00);
      exp_q.push_back(8'hBC); exp_q.push_back(8'h0A);
`ifdef FRAME_CHECKSUM_EN
      exp_q.push_back(8'hB4);
`endif
      push(0, 128'hABC, 12);
      wait_idle("single frame drained", 1000);

      // 2: round robin with same-cycle pushes
      do_reset();
      exp_frame(0, 128'h11, 8); exp_frame(2, 128'h22, 8); exp_frame(2, 128'h33, 8);
      @(negedge clk);
      in_valid = 4'b0101;
      in_data[0 +: MB] = 128'h11;   in_num_bits[0 +: NBW] = 8'd8;
      in_data[2*MB +: MB] = 128'h22; in_num_bits[2*NBW +: NBW] = 8'd8;
      @(negedge clk);
      in_valid = 4'b0100;
      in_data[2*MB +: MB] = 128'h33;
      @(negedge clk);
      in_valid = '0;
      wait_idle("round robin drained", 1500);

      // 3: zero-bit entry discarded
      do_reset();
      exp_q.push_back(8'h01); exp_q.push_back(8'h01); exp_q.push_back(8'h5A);
`ifdef FRAME_CHECKSUM_EN
      exp_q.push_back(8'h5A);
`endif
      push(1, 128'hFF, 0);
      push(1, 128'h5A, 8);
      wait_idle("zero-bit drained", 1000);

      // 4: overflow on ch3 while a long frame holds the UART
      do_reset();
      push(0, long_data, 128);
      exp_frame(0, long_data, 128);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         check("in_ready[3] before push", 32'(in_ready[3]), 1);
         d = 128'(8'hA0) + 128'(i);
         in_valid[3] = 1'b1;
         in_data[3*MB +: MB] = d;
         in_num_bits[3*NBW +: NBW] = 8'd8;
         exp_frame(3, d, 8);
         @(negedge clk);
      end
      check("in_ready[3] when full", 32'(in_ready[3]), 0);
      check("overflow before drop", 32'(overflow), 0);
      in_data[3*MB +: MB] = 128'hEE;
      @(negedge clk);
      check("overflow pulse", 32'(overflow), 32'h8);
      in_valid = '0;
      @(negedge clk);
      check("overflow pulse ends", 32'(overflow), 0);
      wait_idle("overflow frames drained", 3000);

      // 5: bit count clamp
      do_reset();
      push(1, seq_data, 200);
      exp_frame(1, seq_data, 200);
      wait_idle("clamped frame drained", 2000);

      // 6: reset in the middle of the 2nd payload byte
      do_reset();
      rx_before = rx_bytes;
      push(2, long_data, 128);
      exp_frame(2, long_data, 128);
      repeat (5) @(negedge clk);
      push(1, 128'h77, 8);
      found_it = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (rx_bytes == rx_before + 3 && rx_busy && rx_cnt >= 10) begin
            found_it = 1'b1;
            break;
         end
      end
      check("reached 2nd payload byte", 32'(found_it), 1);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check("uart idle after mid-frame reset", 32'(uart_output), 1);
      check("in_ready after mid-frame reset", 32'(in_ready), 32'hF);
      @(negedge clk);
      reset = 1'b0;
      rx_before = rx_bytes;
      line_low_seen = 1'b0;
      repeat (400) @(negedge clk);
      check("no bytes after reset", 32'(rx_bytes - rx_before), 0);
      check("line stayed idle", 32'(line_low_seen), 0);
      check("frame_active low after reset", 32'(frame_active), 0);
      check("in_ready all ones after reset", 32'(in_ready), 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
